// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seqdet_pkg;

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Width needed to hold a length value in the range 0..max_len.
    function automatic int lenw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Lengths beyond the supported maximum fall back to the maximum.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating event counter; clear beats increment.
module seqdet_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count events, hold at all-ones, clear on request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with Mealy match output,
// registered match copy and saturating match counter.
//
//   state | meaning
//   UNCFG | no legal configuration loaded yet, input stream ignored
//   RUN   | configured, accepted bits are shifted in and compared
module seq_detector_prog
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cfg_we,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [lenw(MAX_LEN)-1:0]   cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cnt_clr,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       armed,
    output logic                       match,
    output logic                       match_q,
    output logic [CNT_W-1:0]           match_count
);

    localparam int LW = lenw(MAX_LEN);
    localparam logic [MAX_LEN:0] ONE = (MAX_LEN + 1)'(1);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0]      len_q;
    logic               overlap_q;
    // The newest bit is compared live from in_bit, so only MAX_LEN-1 past
    // bits ever need to be stored.
    logic [MAX_LEN-2:0] hist_q;
    logic [LW-1:0]      fill_q;
    logic               match_r;

    logic               cfg_ok;
    logic [LW-1:0]      cfg_len_c;
    logic               accepted;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] window;
    logic               cmp_ok;
    logic               fill_ok;

    assign cfg_ok    = cfg_we && (cfg_len != '0);
    assign cfg_len_c = LW'(clamp_len(int'(cfg_len), MAX_LEN));
    // A config write steals the cycle, so any bit offered with it is dropped.
    assign accepted  = in_valid && (state_q == RUN) && !cfg_we;

    // Only the low len bits of pattern and history take part in the compare.
    assign mask    = MAX_LEN'((ONE << len_q) - ONE);
    assign window  = {hist_q, in_bit};
    assign cmp_ok  = ((window ^ pattern_q) & mask) == '0;
    assign fill_ok = fill_q >= (len_q - LW'(1));
    assign match   = accepted && fill_ok && cmp_ok;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the first legal config write arms the detector for good.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:   if (cfg_ok) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = UNCFG;
        endcase
    end

    // Configuration registers, reloaded on every legal write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
        end else if (cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_c;
            overlap_q <= cfg_overlap;
        end
    end

    // History shift and fill tracking; non-overlap mode restarts fill after a match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (cfg_ok) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (accepted) begin
            hist_q <= window[MAX_LEN-2:0];
            if (match && !overlap_q) begin
                fill_q <= '0;
            end else if (fill_q < len_q) begin
                fill_q <= fill_q + LW'(1);
            end
        end
    end

    // One-cycle delayed copy of the Mealy match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            match_r <= 1'b0;
        end else begin
            match_r <= match;
        end
    end

    assign match_q = match_r;
    assign armed   = (state_q == RUN);

    seqdet_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (match),
        .clr    (cnt_clr),
        .count  (match_count)
    );

endmodule
